// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU core.
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b1111;
   localparam logic [3:0] OP_AND = 4'b0001;
   localparam logic [3:0] OP_OR  = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_EQ  = 4'b1000;
   localparam logic [3:0] OP_GT  = 4'b0011;
   localparam logic [3:0] OP_SHL = 4'b0110;
   localparam logic [3:0] OP_SHR = 4'b1100;
   localparam logic [3:0] OP_MUL = 4'b0101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_seq_mul #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      count_q;
   logic               busy_q;

   assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   // done coincides with the final iteration so the product is taken straight from acc_next
   assign done     = busy_q && (count_q == CW'(WIDTH - 1));
   assign busy     = busy_q;
   assign product  = acc_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         count_q  <= '0;
         busy_q   <= 1'b0;
      end else if (start) begin
         mcand_q  <= {{WIDTH{1'b0}}, a};
         acc_q    <= '0;
         mplier_q <= b;
         count_q  <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= acc_next;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         count_q  <= count_q + CW'(1);
         if (done) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked ALU core: single-cycle ops complete in one cycle, MUL uses the iterative multiplier.
module alu_seq_core
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [3:0]         sel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               flag_zero,
   output logic               flag_carry,
   output logic               flag_illegal
);

   localparam int unsigned SHW = $clog2(2 * WIDTH);

   state_t state_q, state_d;

   logic [2*WIDTH-1:0] result_q, result_d;
   logic               zero_q, carry_q, illegal_q;
   logic               carry_d, illegal_d, load;

   logic [2*WIDTH-1:0] op_res;
   logic               op_carry, op_illegal;
   logic [WIDTH:0]     sum, diff;
   logic [2*WIDTH-1:0] a_ext;

   logic               mul_start, mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_product;

   alu_seq_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   assign sum   = {1'b0, a} + {1'b0, b};
   assign diff  = {1'b0, a} - {1'b0, b};
   assign a_ext = {{WIDTH{1'b0}}, a};

   always_comb begin
      op_res     = '0;
      op_carry   = 1'b0;
      op_illegal = 1'b0;
      case (sel)
         OP_ADD: begin
            op_res   = {{(WIDTH-1){1'b0}}, sum};
            op_carry = sum[WIDTH];
         end
         OP_SUB: begin
            op_res   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
            op_carry = diff[WIDTH];
         end
         OP_AND:  op_res = {{WIDTH{1'b0}}, a & b};
         OP_OR:   op_res = {{WIDTH{1'b0}}, a | b};
         OP_XOR:  op_res = {{WIDTH{1'b0}}, a ^ b};
         OP_EQ:   op_res = (a == b) ? '1 : '0;
         OP_GT:   op_res = (a > b) ? '1 : '0;
         OP_SHL:  op_res = a_ext << b[SHW-1:0];
         OP_SHR:  op_res = a_ext >> b[SHW-1:0];
         default: op_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mul_start = 1'b0;
      load      = 1'b0;
      result_d  = op_res;
      carry_d   = op_carry;
      illegal_d = op_illegal;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (sel == OP_MUL) begin
                  mul_start = 1'b1;
                  state_d   = ST_MUL;
               end else begin
                  load    = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_MUL: begin
            result_d  = mul_product;
            carry_d   = 1'b0;
            illegal_d = 1'b0;
            if (mul_done) begin
               load    = 1'b1;
               state_d = ST_DONE;
            end else if (!mul_busy) begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q  <= '0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else if (load) begin
         result_q  <= result_d;
         zero_q    <= (result_d == '0);
         carry_q   <= carry_d;
         illegal_q <= illegal_d;
      end
   end

   assign in_ready     = (state_q == ST_IDLE);
   assign out_valid    = (state_q == ST_DONE);
   assign result       = result_q;
   assign flag_zero    = zero_q;
   assign flag_carry   = carry_q;
   assign flag_illegal = illegal_q;

endmodule
